// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receiver (uart_rx_decoder and its FIFO).
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } rx_state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    // Clock cycles per bit period, integer-truncated
    function automatic int calc_div(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    // High when the received parity bit disagrees with the data for the given mode
    function automatic logic parity_bad(input logic [8:0] data, input logic pbit, input int mode);
        logic odd_ones;
        odd_ones = (^data) ^ pbit;
        if (mode == PARITY_ODD) begin
            return ~odd_ones;
        end else begin
            return odd_ones;
        end
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous output FIFO for received bytes. A push into a full FIFO is dropped and
// flagged on overrun, unless a pop happens in the same cycle, which frees the slot first.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     empty,
    output logic                     overrun
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [LW-1:0]    level_r;
    logic             full_s;
    logic             pop_s;
    logic             push_s;

    assign full_s   = (level_r == LW'(DEPTH));
    assign empty    = (level_r == '0);
    assign pop_s    = pop & ~empty;
    assign push_s   = push & (~full_s | pop_s);
    assign overrun  = push & full_s & ~pop_s;
    assign pop_data = mem_r[rd_ptr_r];
    assign level    = level_r;

    // Storage, wrapping pointers and exact occupancy count
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + LW'(1);
                2'b01:   level_r <= level_r - LW'(1);
                default: level_r <= level_r;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_decoder.sv
// UART receiver: 2-flop synchroniser, 3-sample majority bit timer, frame FSM with
// parity/framing/break detection, and an output FIFO drained over valid/ready.
// Optional macro UART_RX_CONSOLE_EN echoes received bytes and error events to the
// simulator console; without it the block produces no simulation output.
module uart_rx_decoder
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115_200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          rx,
    output logic [DATA_BITS-1:0]          rd_data,
    output logic                          rd_valid,
    input  logic                          rd_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overrun,
    output logic                          busy
);
    localparam int DIV = calc_div(CLK_FREQ, BAUD);
    localparam int CW  = $clog2(DIV + 1);
    localparam int BW  = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] SMP_LO  = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] SMP_MID = CW'(DIV / 2);
    localparam logic [CW-1:0] SMP_HI  = CW'(DIV / 2 + 1);
    localparam logic [CW-1:0] PER_END = CW'(DIV - 1);

    logic [1:0]           sync_r;
    logic                 rx_s;
    logic                 rx_prev_r;
    rx_state_t            state_r, state_n;
    logic [CW-1:0]        cnt_r, cnt_n;
    logic [1:0]           vote_r, vote_n;
    logic [BW-1:0]        bit_idx_r, bit_idx_n;
    logic [DATA_BITS-1:0] shift_r, shift_n;
    logic                 par_bad_r, par_bad_n;
    logic                 stop_bad_r, stop_bad_n;
    logic [1:0]           votes_s;
    logic                 bit_val_s;
    logic                 at_hi_s;
    logic                 end_s;
    logic                 fe_s;
    logic                 push_s;
    logic                 empty_s;
    logic                 overrun_s;
    logic                 done_r;
    logic                 frame_err_r;
    logic                 parity_err_r;
    logic                 overrun_r;
    logic                 busy_r;

    assign rx_s      = sync_r[1];
    assign votes_s   = vote_r + {1'b0, rx_s};
    assign bit_val_s = votes_s[1];
    assign at_hi_s   = (cnt_r == SMP_HI);
    // Decision cycle: only frames without parity or framing errors reach the FIFO
    assign push_s    = done_r & ~frame_err_r & ~parity_err_r;

    assign rd_valid   = ~empty_s;
    assign frame_err  = frame_err_r;
    assign parity_err = parity_err_r;
    assign overrun    = overrun_r;
    assign busy       = busy_r;

    // Bring the asynchronous line into the clock domain; idle level is high
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_r    <= 2'b11;
            rx_prev_r <= 1'b1;
        end else begin
            sync_r    <= {sync_r[0], rx};
            rx_prev_r <= rx_s;
        end
    end

    // Frame FSM: bit timer, majority voting, data shift and error collection
    always_comb begin
        state_n    = state_r;
        cnt_n      = cnt_r;
        vote_n     = vote_r;
        bit_idx_n  = bit_idx_r;
        shift_n    = shift_r;
        par_bad_n  = par_bad_r;
        stop_bad_n = stop_bad_r;
        end_s      = 1'b0;
        fe_s       = 1'b0;
        case (state_r)
            IDLE: begin
                cnt_n     = '0;
                vote_n    = 2'd0;
                bit_idx_n = '0;
                if (rx_prev_r && !rx_s) begin
                    // The edge cycle itself is position 0 of the start bit
                    state_n    = START;
                    cnt_n      = CW'(1);
                    par_bad_n  = 1'b0;
                    stop_bad_n = 1'b0;
                end else begin
                    state_n = IDLE;
                end
            end
            BREAK: begin
                cnt_n  = '0;
                vote_n = 2'd0;
                if (rx_s) begin
                    state_n = IDLE;
                end else begin
                    state_n = BREAK;
                end
            end
            START, DATA, uart_pkg::PARITY, STOP: begin
                cnt_n = (cnt_r == PER_END) ? '0 : cnt_r + CW'(1);
                if (cnt_r == SMP_LO || cnt_r == SMP_MID) begin
                    vote_n = votes_s;
                end else if (at_hi_s) begin
                    vote_n = 2'd0;
                end else begin
                    vote_n = vote_r;
                end
                if (at_hi_s) begin
                    case (state_r)
                        START: begin
                            if (bit_val_s) begin
                                state_n = IDLE;
                            end else begin
                                state_n = DATA;
                            end
                        end
                        DATA: begin
                            shift_n = {bit_val_s, shift_r[DATA_BITS-1:1]};
                            if (bit_idx_r == BW'(DATA_BITS - 1)) begin
                                bit_idx_n = '0;
                                state_n   = (PARITY != PARITY_NONE) ? uart_pkg::PARITY : STOP;
                            end else begin
                                bit_idx_n = bit_idx_r + BW'(1);
                            end
                        end
                        uart_pkg::PARITY: begin
                            par_bad_n = parity_bad(9'(shift_r), bit_val_s, PARITY);
                            state_n   = STOP;
                        end
                        STOP: begin
                            stop_bad_n = stop_bad_r | ~bit_val_s;
                            if (bit_idx_r == BW'(STOP_BITS - 1)) begin
                                // Leave at mid last stop bit so the next start edge is caught
                                end_s     = 1'b1;
                                fe_s      = stop_bad_r | ~bit_val_s;
                                bit_idx_n = '0;
                                state_n   = (shift_r == '0 && !bit_val_s) ? BREAK : IDLE;
                            end else begin
                                bit_idx_n = bit_idx_r + BW'(1);
                            end
                        end
                        default: state_n = IDLE;
                    endcase
                end else begin
                    state_n = state_r;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // FSM state and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= IDLE;
            cnt_r      <= '0;
            vote_r     <= 2'd0;
            bit_idx_r  <= '0;
            shift_r    <= '0;
            par_bad_r  <= 1'b0;
            stop_bad_r <= 1'b0;
        end else begin
            state_r    <= state_n;
            cnt_r      <= cnt_n;
            vote_r     <= vote_n;
            bit_idx_r  <= bit_idx_n;
            shift_r    <= shift_n;
            par_bad_r  <= par_bad_n;
            stop_bad_r <= stop_bad_n;
        end
    end

    // Registered status: error pulses line up with the frame decision cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done_r       <= 1'b0;
            frame_err_r  <= 1'b0;
            parity_err_r <= 1'b0;
            overrun_r    <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            done_r       <= end_s;
            frame_err_r  <= end_s & fe_s;
            parity_err_r <= end_s & par_bad_r;
            overrun_r    <= overrun_s;
            busy_r       <= (state_n != IDLE);
        end
    end

    uart_rx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push_s),
        .push_data (shift_r),
        .pop       (rd_ready),
        .pop_data  (rd_data),
        .level     (fifo_level),
        .empty     (empty_s),
        .overrun   (overrun_s)
    );

`ifdef UART_RX_CONSOLE_EN
    // Console echo of accepted bytes and error events
    always @(posedge clk) begin
        if (push_s) begin
            $write("%c", shift_r);
        end
        if (frame_err_r) begin
            $display("%t uart_rx_decoder: framing error", $time);
        end
        if (parity_err_r) begin
            $display("%t uart_rx_decoder: parity error", $time);
        end
        if (overrun_r) begin
            $display("%t uart_rx_decoder: overrun, byte dropped", $time);
        end
    end
`else
`endif

endmodule

// File: tb/tb_uart_rx_decoder.sv
// Self-checking bench for uart_rx_decoder: three instances (8N1, even parity, 4-deep FIFO)
// driven by a bit-level serial transmitter; expected bytes and error counts come from the
// frame rules applied to what the bench sent.
module tb_uart_rx_decoder;

    localparam int CLK_FREQ = 5_000_000;
    localparam int BAUD     = 100_000;
    localparam int CLK_NS   = 10;
    localparam int BIT_NS   = (CLK_FREQ / BAUD) * CLK_NS;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic rx0 = 1'b1, rx1 = 1'b1, rx2 = 1'b1;
    logic ready0 = 1'b1, ready1 = 1'b1, ready2 = 1'b0;

    logic [7:0] data0, data1, data2;
    logic       valid0, valid1, valid2;
    logic [4:0] level0, level1;
    logic [2:0] level2;
    logic       fe0, fe1, fe2, pe0, pe1, pe2, ov0, ov1, ov2, busy0, busy1, busy2;

    int checks = 0;
    int errors = 0;
    int fe_cnt [3] = '{0, 0, 0};
    int pe_cnt [3] = '{0, 0, 0};
    int ov_cnt [3] = '{0, 0, 0};
    logic [7:0] cap0 [$];
    logic [7:0] cap1 [$];
    logic [7:0] cap2 [$];

    always #(CLK_NS / 2) clk = ~clk;

    uart_rx_decoder #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(0),
                      .STOP_BITS(1), .FIFO_DEPTH(16)) u_dut (
        .clk(clk), .reset_n(reset_n), .rx(rx0), .rd_data(data0), .rd_valid(valid0),
        .rd_ready(ready0), .fifo_level(level0), .frame_err(fe0), .parity_err(pe0),
        .overrun(ov0), .busy(busy0));

    uart_rx_decoder #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(2),
                      .STOP_BITS(1), .FIFO_DEPTH(16)) u_par (
        .clk(clk), .reset_n(reset_n), .rx(rx1), .rd_data(data1), .rd_valid(valid1),
        .rd_ready(ready1), .fifo_level(level1), .frame_err(fe1), .parity_err(pe1),
        .overrun(ov1), .busy(busy1));

    uart_rx_decoder #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(0),
                      .STOP_BITS(1), .FIFO_DEPTH(4)) u_fif (
        .clk(clk), .reset_n(reset_n), .rx(rx2), .rd_data(data2), .rd_valid(valid2),
        .rd_ready(ready2), .fifo_level(level2), .frame_err(fe2), .parity_err(pe2),
        .overrun(ov2), .busy(busy2));

    // Count error pulses and record each popped byte, sampled mid-cycle
    always @(negedge clk) begin
        fe_cnt[0] <= fe_cnt[0] + (fe0 ? 1 : 0);
        fe_cnt[1] <= fe_cnt[1] + (fe1 ? 1 : 0);
        fe_cnt[2] <= fe_cnt[2] + (fe2 ? 1 : 0);
        pe_cnt[0] <= pe_cnt[0] + (pe0 ? 1 : 0);
        pe_cnt[1] <= pe_cnt[1] + (pe1 ? 1 : 0);
        pe_cnt[2] <= pe_cnt[2] + (pe2 ? 1 : 0);
        ov_cnt[0] <= ov_cnt[0] + (ov0 ? 1 : 0);
        ov_cnt[1] <= ov_cnt[1] + (ov1 ? 1 : 0);
        ov_cnt[2] <= ov_cnt[2] + (ov2 ? 1 : 0);
        if (valid0 && ready0) cap0.push_back(data0);
        if (valid1 && ready1) cap1.push_back(data1);
        if (valid2 && ready2) cap2.push_back(data2);
    end

    task automatic drive(input int sel, input logic v);
        case (sel)
            0:       rx0 = v;
            1:       rx1 = v;
            default: rx2 = v;
        endcase
    endtask

    // Serial transmitter: start, 8 data LSB first, optional parity, one stop, one idle bit
    task automatic send_frame(input int sel, input logic [7:0] d, input int pmode,
                              input bit flip, input logic stop_v, input int bit_ns);
        int   ones;
        logic p;
        ones = 0;
        drive(sel, 1'b0);
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            drive(sel, d[i]);
            ones += (d[i] ? 1 : 0);
            #(bit_ns);
        end
        if (pmode != 0) begin
            p = (pmode == 2) ? ((ones % 2) == 1) : ((ones % 2) == 0);
            if (flip) p = ~p;
            drive(sel, p);
            #(bit_ns);
        end
        drive(sel, stop_v);
        #(bit_ns);
        drive(sel, 1'b1);
        #(bit_ns);
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        for (int i = 0; i < 20; i++) begin
            rx0 = ~rx0; rx1 = ~rx1; rx2 = ~rx2;
            #(CLK_NS);
        end
        rx0 = 1'b1; rx1 = 1'b1; rx2 = 1'b1;
        #(CLK_NS * 3);
        checks++;
        if ({valid0, level0, fe0, pe0, ov0, busy0, data0} !== 18'h0)
            begin errors++; $display("FAIL reset_dut got %h want 0", {valid0, level0, fe0, pe0, ov0, busy0, data0}); end
        checks++;
        if ({valid1, level1, fe1, pe1, ov1, busy1, data1} !== 18'h0)
            begin errors++; $display("FAIL reset_par got %h want 0", {valid1, level1, fe1, pe1, ov1, busy1, data1}); end
        checks++;
        if ({valid2, level2, fe2, pe2, ov2, busy2, data2} !== 16'h0)
            begin errors++; $display("FAIL reset_fif got %h want 0", {valid2, level2, fe2, pe2, ov2, busy2, data2}); end
        reset_n = 1'b1;
        #(CLK_NS * 5);
    endtask

    task automatic test_reset_midframe;
        int errs;
        errs = fe_cnt[2] + pe_cnt[2] + ov_cnt[2];
        send_frame(2, 8'hC3, 0, 1'b0, 1'b1, BIT_NS);
        checks++;
        if (level2 !== 3'd1) begin errors++; $display("FAIL midrst_preload got %0d want 1", level2); end
        drive(2, 1'b0);
        #(BIT_NS * 3);
        reset_n = 1'b0;
        #(CLK_NS * 2);
        checks++;
        if ({valid2, level2, busy2} !== 5'd0)
            begin errors++; $display("FAIL midrst_clear got %h want 0", {valid2, level2, busy2}); end
        drive(2, 1'b1);
        #(CLK_NS * 2);
        reset_n = 1'b1;
        #(BIT_NS * 2);
        checks++;
        if (fe_cnt[2] + pe_cnt[2] + ov_cnt[2] !== errs)
            begin errors++; $display("FAIL midrst_pulses got %0d want %0d", fe_cnt[2] + pe_cnt[2] + ov_cnt[2], errs); end
        checks++;
        if (busy2 !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy2); end
    endtask

    task automatic test_basic;
        int n, errs;
        n = cap0.size();
        errs = fe_cnt[0] + pe_cnt[0] + ov_cnt[0];
        send_frame(0, 8'h41, 0, 1'b0, 1'b1, BIT_NS);
        send_frame(0, 8'h0A, 0, 1'b0, 1'b1, BIT_NS);
        #(CLK_NS * 10);
        checks++;
        if (cap0.size() !== n + 2) begin
            errors++; $display("FAIL basic_count got %0d want %0d", cap0.size(), n + 2);
        end else begin
            checks++;
            if (cap0[n] !== 8'h41) begin errors++; $display("FAIL basic_byte0 got %h want 41", cap0[n]); end
            checks++;
            if (cap0[n+1] !== 8'h0A) begin errors++; $display("FAIL basic_byte1 got %h want 0a", cap0[n+1]); end
        end
        checks++;
        if (fe_cnt[0] + pe_cnt[0] + ov_cnt[0] !== errs)
            begin errors++; $display("FAIL basic_pulses got %0d want %0d", fe_cnt[0] + pe_cnt[0] + ov_cnt[0], errs); end
    endtask

    task automatic test_parity;
        int n, f, p;
        n = cap1.size(); f = fe_cnt[1]; p = pe_cnt[1];
        send_frame(1, 8'h55, 2, 1'b1, 1'b1, BIT_NS);
        checks++;
        if (pe_cnt[1] !== p + 1) begin errors++; $display("FAIL parity_pulse got %0d want %0d", pe_cnt[1], p + 1); end
        checks++;
        if (fe_cnt[1] !== f) begin errors++; $display("FAIL parity_no_fe got %0d want %0d", fe_cnt[1], f); end
        checks++;
        if (level1 !== 5'd0 || cap1.size() !== n)
            begin errors++; $display("FAIL parity_empty got level %0d pops %0d want 0 %0d", level1, cap1.size(), n); end
        send_frame(1, 8'h55, 2, 1'b0, 1'b1, BIT_NS);
        checks++;
        if (cap1.size() !== n + 1) begin
            errors++; $display("FAIL parity_good_count got %0d want %0d", cap1.size(), n + 1);
        end else if (cap1[n] !== 8'h55) begin
            errors++; $display("FAIL parity_good_byte got %h want 55", cap1[n]);
        end
    endtask

    task automatic test_break;
        int n, f, other;
        n = cap0.size(); f = fe_cnt[0]; other = pe_cnt[0] + ov_cnt[0];
        send_frame(0, 8'h33, 0, 1'b0, 1'b0, BIT_NS);
        checks++;
        if (fe_cnt[0] !== f + 1) begin errors++; $display("FAIL break_stop_fe got %0d want %0d", fe_cnt[0], f + 1); end
        rx0 = 1'b0;
        #(BIT_NS * 20);
        checks++;
        if (fe_cnt[0] !== f + 2) begin errors++; $display("FAIL break_fe got %0d want %0d", fe_cnt[0], f + 2); end
        checks++;
        if (busy0 !== 1'b1) begin errors++; $display("FAIL break_busy got %b want 1", busy0); end
        rx0 = 1'b1;
        #(CLK_NS * 10);
        checks++;
        if (busy0 !== 1'b0) begin errors++; $display("FAIL break_release got %b want 0", busy0); end
        #(BIT_NS);
        send_frame(0, 8'h7E, 0, 1'b0, 1'b1, BIT_NS);
        checks++;
        if (cap0.size() !== n + 1) begin
            errors++; $display("FAIL break_next_count got %0d want %0d", cap0.size(), n + 1);
        end else if (cap0[n] !== 8'h7E) begin
            errors++; $display("FAIL break_next_byte got %h want 7e", cap0[n]);
        end
        checks++;
        if (fe_cnt[0] !== f + 2 || pe_cnt[0] + ov_cnt[0] !== other)
            begin errors++; $display("FAIL break_total got fe %0d want %0d", fe_cnt[0], f + 2); end
    endtask

    task automatic test_overrun;
        int n, o;
        n = cap2.size(); o = ov_cnt[2];
        ready2 = 1'b0;
        for (int i = 1; i <= 5; i++) send_frame(2, 8'(i), 0, 1'b0, 1'b1, BIT_NS);
        checks++;
        if (level2 !== 3'd4) begin errors++; $display("FAIL ovr_level got %0d want 4", level2); end
        checks++;
        if (ov_cnt[2] !== o + 1) begin errors++; $display("FAIL ovr_pulse got %0d want %0d", ov_cnt[2], o + 1); end
        checks++;
        if (valid2 !== 1'b1 || data2 !== 8'h01)
            begin errors++; $display("FAIL ovr_head got %b %h want 1 01", valid2, data2); end
        ready2 = 1'b1;
        #(CLK_NS * 10);
        ready2 = 1'b0;
        checks++;
        if (cap2.size() !== n + 4) begin
            errors++; $display("FAIL ovr_pops got %0d want %0d", cap2.size(), n + 4);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (cap2[n+i] !== 8'(i + 1))
                    begin errors++; $display("FAIL ovr_byte%0d got %h want %h", i, cap2[n+i], 8'(i + 1)); end
            end
        end
        checks++;
        if (level2 !== 3'd0) begin errors++; $display("FAIL ovr_drained got %0d want 0", level2); end
    endtask

    task automatic test_glitch_skew;
        int n, errs;
        n = cap0.size();
        errs = fe_cnt[0] + pe_cnt[0] + ov_cnt[0];
        rx0 = 1'b0;
        #(CLK_NS * (CLK_FREQ / BAUD) / 4);
        rx0 = 1'b1;
        #(BIT_NS * 2);
        checks++;
        if (busy0 !== 1'b0 || cap0.size() !== n || level0 !== 5'd0)
            begin errors++; $display("FAIL glitch got busy %b pops %0d want 0 %0d", busy0, cap0.size(), n); end
        checks++;
        if (fe_cnt[0] + pe_cnt[0] + ov_cnt[0] !== errs)
            begin errors++; $display("FAIL glitch_pulses got %0d want %0d", fe_cnt[0] + pe_cnt[0] + ov_cnt[0], errs); end
        send_frame(0, 8'hA5, 0, 1'b0, 1'b1, BIT_NS - BIT_NS / 50);
        send_frame(0, 8'hA5, 0, 1'b0, 1'b1, BIT_NS + BIT_NS / 50);
        #(CLK_NS * 10);
        checks++;
        if (cap0.size() !== n + 2) begin
            errors++; $display("FAIL skew_count got %0d want %0d", cap0.size(), n + 2);
        end else if (cap0[n] !== 8'hA5 || cap0[n+1] !== 8'hA5) begin
            errors++; $display("FAIL skew_bytes got %h %h want a5 a5", cap0[n], cap0[n+1]);
        end
    endtask

    task automatic test_random;
        logic [7:0] exp_q [$];
        int   n, f, p, exp_f, exp_p;
        logic [7:0] d;
        bit   flip;
        logic stop_v;
        n = cap1.size(); f = fe_cnt[1]; p = pe_cnt[1];
        exp_f = 0; exp_p = 0;
        for (int i = 0; i < 12; i++) begin
            d      = 8'($urandom);
            flip   = ($urandom_range(3) == 0);
            stop_v = ($urandom_range(5) != 0);
            send_frame(1, d, 2, flip, stop_v, BIT_NS);
            if (flip) exp_p++;
            if (!stop_v) exp_f++;
            if (!flip && stop_v) exp_q.push_back(d);
        end
        #(CLK_NS * 10);
        checks++;
        if (cap1.size() - n !== exp_q.size()) begin
            errors++; $display("FAIL rand_count got %0d want %0d", cap1.size() - n, exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (cap1[n+i] !== exp_q[i])
                    begin errors++; $display("FAIL rand_byte%0d got %h want %h", i, cap1[n+i], exp_q[i]); end
            end
        end
        checks++;
        if (fe_cnt[1] - f !== exp_f) begin errors++; $display("FAIL rand_fe got %0d want %0d", fe_cnt[1] - f, exp_f); end
        checks++;
        if (pe_cnt[1] - p !== exp_p) begin errors++; $display("FAIL rand_pe got %0d want %0d", pe_cnt[1] - p, exp_p); end
    endtask

    initial begin
        @(posedge clk);
        #2;
        test_reset();
        test_reset_midframe();
        test_basic();
        test_parity();
        test_break();
        test_overrun();
        test_glitch_skew();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
